i2c_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one i2c_master between NREQ on-chip requesters. It accepts a single-byte transaction from one requester at a time: 7-bit address, write data and rw. It drives the master's start/addr/wdata/rw and returns rdata plus completion status to the owning requester. A watchdog bounds each transaction and reports a timeout error if the master never signals done.

---
 rtl/i2c_pkg.sv | 17 +
 rtl/i2c_arbiter_rr_pick.sv | 32 +++
 rtl/i2c_arbiter.sv | 149 ++++++++++++++
 tb/tb_i2c_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and widths for the i2c requester arbiter.
//   ADDR_W      : 7-bit i2c slave address
//   DATA_W      : single data byte per transaction
//   arb_state_t : sequencer states
package i2c_pkg;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        DRAIN = 2'd3
    } arb_state_t;

endpackage

// File: rtl/i2c_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
//   req    : per-requester request vector
//   ptr    : index searched first
//   valid  : any request present
//   winner : index of the selected requester
module rr_pick #(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] winner
);

    logic [IDX_W-1:0] cand;

    // Walk outward from ptr; the first hit locks the result.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            cand = IDX_W'((int'(ptr) + k) % int'(NREQ));
            if (!valid && req[cand]) begin
                valid  = 1'b1;
                winner = cand;
            end
        end
    end

endmodule

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter/sequencer sharing one i2c_master among NREQ requesters.
//   clk, rst                         : clock, async active-high reset
//   req, req_addr, req_wdata, req_rw : per-requester transaction request
//   gnt                              : one-hot accept pulse
//   resp_valid, resp_rdata, resp_err : one-hot completion pulse + result
//   busy                             : sequencer not idle
//   m_start, m_addr, m_wdata, m_rw   : command to i2c_master
//   m_rdata, m_done                  : completion from i2c_master
module i2c_arbiter
    import i2c_pkg::*;
#(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [ADDR_W*NREQ-1:0] req_addr,
    input  logic [DATA_W*NREQ-1:0] req_wdata,
    input  logic [NREQ-1:0]        req_rw,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        resp_valid,
    output logic [DATA_W-1:0]      resp_rdata,
    output logic                   resp_err,
    output logic                   busy,
    output logic                   m_start,
    output logic [ADDR_W-1:0]      m_addr,
    output logic [DATA_W-1:0]      m_wdata,
    output logic                   m_rw,
    input  logic [DATA_W-1:0]      m_rdata,
    input  logic                   m_done
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  wd_q, wd_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d, rdata_d;
    logic              rw_d, start_d, err_d, busy_d;
    logic [NREQ-1:0]   gnt_d, rv_d;
    logic              pick_valid;
    logic [IDX_W-1:0]  pick_w;

    rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .valid  (pick_valid),
        .winner (pick_w)
    );

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            ptr_q      <= '0;
            wd_q       <= '0;
            m_addr     <= '0;
            m_wdata    <= '0;
            m_rw       <= 1'b0;
            m_start    <= 1'b0;
            gnt        <= '0;
            resp_valid <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            wd_q       <= wd_d;
            m_addr     <= addr_d;
            m_wdata    <= wdata_d;
            m_rw       <= rw_d;
            m_start    <= start_d;
            gnt        <= gnt_d;
            resp_valid <= rv_d;
            resp_rdata <= rdata_d;
            resp_err   <= err_d;
            busy       <= busy_d;
        end
    end

    // Next-state and next-output logic.
    // The watchdog counts cycles since m_start: zero in the start cycle.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        wd_d    = wd_q;
        addr_d  = m_addr;
        wdata_d = m_wdata;
        rw_d    = m_rw;
        start_d = 1'b0;
        gnt_d   = '0;
        rv_d    = '0;
        rdata_d = resp_rdata;
        err_d   = resp_err;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = ISSUE;
                    owner_d = pick_w;
                    addr_d  = req_addr[ADDR_W*pick_w +: ADDR_W];
                    wdata_d = req_wdata[DATA_W*pick_w +: DATA_W];
                    rw_d    = req_rw[pick_w];
                    gnt_d   = NREQ'(1) << pick_w;
                    start_d = 1'b1;
                    wd_d    = '0;
                end
            end
            ISSUE: begin
                state_d = BUSY;
                ptr_d   = (owner_q == IDX_W'(NREQ - 1)) ? '0 : owner_q + 1'b1;
                wd_d    = wd_q + 1'b1;
            end
            BUSY: begin
                wd_d = wd_q + 1'b1;
                // m_done takes precedence over a coincident timeout.
                if (m_done) begin
                    state_d = IDLE;
                    rv_d    = NREQ'(1) << owner_q;
                    err_d   = 1'b0;
                    rdata_d = m_rw ? m_rdata : '0;
                end else if (wd_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = DRAIN;
                    rv_d    = NREQ'(1) << owner_q;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            DRAIN: begin
                // Error already reported; just wait for the master to finish.
                if (m_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed self-checking bench for i2c_arbiter (NREQ=2).
// u_dut uses a long watchdog; u_dut_to shares all inputs and uses TIMEOUT=16.
module tb_i2c_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [13:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_rw;
    logic [7:0]  m_rdata;
    logic        m_done;

    logic [1:0]  gnt, resp_valid;
    logic [7:0]  resp_rdata, m_wdata;
    logic [6:0]  m_addr;
    logic        resp_err, busy, m_start, m_rw;

    logic [1:0]  gnt_t, resp_valid_t;
    logic [7:0]  resp_rdata_t, m_wdata_t;
    logic [6:0]  m_addr_t;
    logic        resp_err_t, busy_t, m_start_t, m_rw_t;

    int n_checks = 0;
    int n_errors = 0;

    i2c_arbiter #(.NREQ(2), .TIMEOUT(64)) u_dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rw(req_rw), .gnt(gnt),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .busy(busy), .m_start(m_start), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rw(m_rw), .m_rdata(m_rdata), .m_done(m_done)
    );

    i2c_arbiter #(.NREQ(2), .TIMEOUT(16)) u_dut_to (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rw(req_rw), .gnt(gnt_t),
        .resp_valid(resp_valid_t), .resp_rdata(resp_rdata_t), .resp_err(resp_err_t),
        .busy(busy_t), .m_start(m_start_t), .m_addr(m_addr_t), .m_wdata(m_wdata_t),
        .m_rw(m_rw_t), .m_rdata(m_rdata), .m_done(m_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One transaction on u_dut: request, grant next cycle, done lat cycles after start.
    task automatic run_txn(input int who, input logic [6:0] a, input logic [7:0] wd,
                           input logic rw, input int lat, input logic [7:0] rd);
        logic [1:0] oh;
        oh = 2'b01 << who;
        req_addr[7*who +: 7]  = a;
        req_wdata[8*who +: 8] = wd;
        req_rw[who]           = rw;
        req[who]              = 1'b1;
        @(negedge clk);
        check("txn_gnt",     32'(gnt), 32'(oh));
        check("txn_start",   32'(m_start), 1);
        check("txn_addr",    32'(m_addr), 32'(a));
        check("txn_wdata",   32'(m_wdata), 32'(wd));
        check("txn_rw",      32'(m_rw), 32'(rw));
        check("txn_busy",    32'(busy), 1);
        req[who] = 1'b0;
        repeat (lat) @(negedge clk);
        check("txn_early",   32'(resp_valid), 0);
        check("txn_hold",    32'(m_addr), 32'(a));
        m_done  = 1'b1;
        m_rdata = rd;
        @(negedge clk);
        m_done = 1'b0;
        check("txn_resp",    32'(resp_valid), 32'(oh));
        check("txn_rdata",   32'(resp_rdata), 32'(rw ? rd : 8'h00));
        check("txn_err",     32'(resp_err), 0);
        check("txn_idle",    32'(busy), 0);
        @(negedge clk);
        check("txn_pulse",   32'(resp_valid), 0);
        check("txn_rdhold",  32'(resp_rdata), 32'(rw ? rd : 8'h00));
    endtask

    initial begin
        logic [1:0] exp_g;
        rst = 1'b1; req = '0; req_addr = '0; req_wdata = '0; req_rw = '0;
        m_rdata = '0; m_done = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_gnt",   32'(gnt), 0);
        check("rst_start", 32'(m_start), 0);
        check("rst_busy",  32'(busy), 0);
        check("rst_resp",  32'(resp_valid), 0);
        check("rst_maddr", 32'(m_addr), 0);
        check("rst_busy_t", 32'(busy_t), 0);
        rst = 1'b0;
        @(negedge clk);

        // Write from req0, then read from req1.
        run_txn(0, 7'h50, 8'h5A, 1'b0, 20, 8'hEE);
        run_txn(1, 7'h3C, 8'h00, 1'b1, 5,  8'hA7);

        // Both requesters held from reset: alternate 0,1,0,1.
        do_reset();
        req_addr = {7'h22, 7'h11}; req_wdata = {8'hB2, 8'hB1}; req_rw = 2'b00;
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 1) ? 2'b10 : 2'b01;
            @(negedge clk);
            check("rr_gnt",   32'(gnt), 32'(exp_g));
            check("rr_start", 32'(m_start), 1);
            check("rr_addr",  32'(m_addr), (i % 2 == 1) ? 'h22 : 'h11);
            @(negedge clk);
            check("rr_gnt_pulse", 32'(gnt), 0);
            check("rr_start_pulse", 32'(m_start), 0);
            @(negedge clk);
            check("rr_no_overlap", 32'(m_start), 0);
            m_done = 1'b1;
            @(negedge clk);
            m_done = 1'b0;
            check("rr_resp", 32'(resp_valid), 32'(exp_g));
            if (i == 3) req = 2'b00;
        end
        @(negedge clk);
        check("rr_quiet", 32'(gnt), 0);

        // Watchdog on u_dut_to: no done -> error at start+16, then DRAIN.
        do_reset();
        req_addr = {7'h3C, 7'h50}; req_wdata = {8'h00, 8'h5A}; req_rw = 2'b10;
        req = 2'b11;
        @(negedge clk);
        check("to_gnt",   32'(gnt_t), 1);
        check("to_start", 32'(m_start_t), 1);
        req = 2'b10;
        for (int k = 1; k < 16; k++) begin
            @(negedge clk);
            check("to_early", 32'(resp_valid_t), 0);
        end
        @(negedge clk);
        check("to_resp",  32'(resp_valid_t), 1);
        check("to_err",   32'(resp_err_t), 1);
        check("to_rdata", 32'(resp_rdata_t), 0);
        check("to_busy",  32'(busy_t), 1);
        repeat (5) @(negedge clk);
        check("drain_busy",  32'(busy_t), 1);
        check("drain_resp",  32'(resp_valid_t), 0);
        check("drain_gnt",   32'(gnt_t), 0);
        check("drain_hold",  32'(m_addr_t), 'h50);
        check("drain_errhold", 32'(resp_err_t), 1);
        m_done = 1'b1;
        @(negedge clk);
        m_done = 1'b0;
        check("drain_no_resp", 32'(resp_valid_t), 0);
        check("drain_idle",    32'(busy_t), 0);
        @(negedge clk);
        check("drain_next_gnt", 32'(gnt_t), 2);
        req = 2'b00;

        // Reset mid-transaction on u_dut.
        do_reset();
        req_addr = {7'h3C, 7'h50}; req_wdata = {8'h00, 8'h5A}; req_rw = 2'b01;
        req = 2'b01;
        @(negedge clk);
        check("mid_gnt", 32'(gnt), 1);
        req = 2'b00;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_busy",  32'(busy), 0);
        check("mid_rst_maddr", 32'(m_addr), 0);
        check("mid_rst_mwdat", 32'(m_wdata), 0);
        check("mid_rst_mrw",   32'(m_rw), 0);
        check("mid_rst_resp",  32'(resp_valid), 0);
        check("mid_rst_err",   32'(resp_err), 0);
        check("mid_rst_rdata", 32'(resp_rdata), 0);
        check("mid_rst_gnt",   32'(gnt), 0);
        check("mid_rst_start", 32'(m_start), 0);
        @(negedge clk);
        rst = 1'b0;
        req = 2'b10;
        @(negedge clk);
        check("post_rst_gnt",  32'(gnt), 2);
        check("post_rst_addr", 32'(m_addr), 'h3C);
        req = 2'b00;
        @(negedge clk);
        m_done = 1'b1;
        @(negedge clk);
        m_done = 1'b0;
        check("post_rst_resp", 32'(resp_valid), 2);

        // Stray m_done in IDLE is ignored.
        @(negedge clk);
        m_done = 1'b1;
        @(negedge clk);
        m_done = 1'b0;
        check("stray_resp", 32'(resp_valid), 0);
        check("stray_busy", 32'(busy), 0);
        check("stray_gnt",  32'(gnt), 0);
        @(negedge clk);
        check("stray_resp2", 32'(resp_valid), 0);
        run_txn(0, 7'h12, 8'h34, 1'b0, 3, 8'h99);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
